// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: load/store size encodings and the LSU state
// enum, plus helpers that classify a funct3/address pair.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_DONE = 2'd2
  } lsu_state_e;

  // Stores have no unsigned variants, so only B/H/W are legal for them.
  function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = !is_store;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic addr_aligned(input logic [2:0] f3, input logic [1:0] lo);
    logic ok;
    case (f3)
      F3_H, F3_HU: ok = (lo[0] == 1'b0);
      F3_W:        ok = (lo == 2'b00);
      default:     ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store data replication and byte enables,
// and load byte/half extraction with sign or zero extension.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  byte_off_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] load_word_i,
  output logic [31:0] store_wdata_o,
  output logic [3:0]  store_be_o,
  output logic [31:0] load_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    store_wdata_o = store_data_i;
    store_be_o    = 4'b1111;
    case (funct3_i)
      F3_B: begin
        store_wdata_o = {4{store_data_i[7:0]}};
        store_be_o    = 4'b0001 << byte_off_i;
      end
      F3_H: begin
        store_wdata_o = {2{store_data_i[15:0]}};
        store_be_o    = 4'b0011 << {byte_off_i[1], 1'b0};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (byte_off_i)
      2'd0:    ld_byte = load_word_i[7:0];
      2'd1:    ld_byte = load_word_i[15:8];
      2'd2:    ld_byte = load_word_i[23:16];
      default: ld_byte = load_word_i[31:24];
    endcase
    ld_half = byte_off_i[1] ? load_word_i[31:16] : load_word_i[15:0];
  end

  always_comb begin
    case (funct3_i)
      F3_B:    load_data_o = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   load_data_o = {24'd0, ld_byte};
      F3_H:    load_data_o = {{16{ld_half[15]}}, ld_half};
      F3_HU:   load_data_o = {16'd0, ld_half};
      default: load_data_o = load_word_i;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// M-stage load/store unit: one req/ack bus transaction per access, with
// stall_m held until the completion cycle so any memory latency is absorbed.
module mem_stage_lsu
  import riscv_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mem_read_m,
  input  logic                     mem_write_m,
  input  logic [2:0]               funct3_m,
  input  logic [ADDRESS_WIDTH-1:0] alu_result_m,
  input  logic [DATA_WIDTH-1:0]    write_data_m,
  output logic                     dmem_req,
  output logic                     dmem_we,
  output logic [ADDRESS_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0]    dmem_wdata,
  output logic [3:0]               dmem_be,
  input  logic                     dmem_ack,
  input  logic [DATA_WIDTH-1:0]    dmem_rdata,
  output logic [DATA_WIDTH-1:0]    read_data_m,
  output logic                     stall_m,
  output logic                     access_fault_m
);

  lsu_state_e state_q, state_d;

  logic                     req_q, req_d;
  logic                     we_q, we_d;
  logic [3:0]               be_q, be_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;

  logic                  one_dir;
  logic                  access_valid;
  logic [DATA_WIDTH-1:0] store_wdata;
  logic [3:0]            store_be;
  logic [DATA_WIDTH-1:0] load_data;

  assign one_dir      = mem_read_m ^ mem_write_m;
  assign access_valid = one_dir
                      && f3_legal(funct3_m, mem_write_m)
                      && addr_aligned(funct3_m, alu_result_m[1:0]);

  lsu_align u_align (
    .funct3_i     (funct3_m),
    .byte_off_i   (alu_result_m[1:0]),
    .store_data_i (write_data_m),
    .load_word_i  (rdata_q),
    .store_wdata_o(store_wdata),
    .store_be_o   (store_be),
    .load_data_o  (load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LSU_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LSU_IDLE: if (access_valid) state_d = LSU_REQ;
      LSU_REQ:  if (dmem_ack) state_d = LSU_DONE;
      LSU_DONE: state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  // Bus fields launch on IDLE->REQ and stay frozen until the ack retires them;
  // addr/wdata are deliberately left holding after completion.
  always_comb begin
    req_d   = req_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    if (state_q == LSU_IDLE && access_valid) begin
      req_d   = 1'b1;
      we_d    = mem_write_m;
      be_d    = mem_write_m ? store_be : 4'b1111;
      addr_d  = {alu_result_m[ADDRESS_WIDTH-1:2], 2'b00};
      wdata_d = store_wdata;
    end else if (state_q == LSU_REQ && dmem_ack) begin
      req_d   = 1'b0;
      we_d    = 1'b0;
      be_d    = 4'b0000;
      rdata_d = dmem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= 4'b0000;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      req_q   <= req_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_be    = be_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;

  always_comb begin
    stall_m        = 1'b0;
    access_fault_m = 1'b0;
    read_data_m    = '0;
    if (!rst) begin
      stall_m        = access_valid && (state_q != LSU_DONE);
      access_fault_m = (mem_read_m || mem_write_m) && !access_valid;
    end
    if (state_q == LSU_DONE && access_valid && mem_read_m) begin
      read_data_m = load_data;
    end
  end

endmodule
